// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and pixel types for the VGA raster output.
//   - default 640x480@60 horizontal/vertical timing plus derived totals and
//     sync start/end positions
//   - rgb8_t    : RRRGGGBB colour as returned by the objects mux
//   - rgb12_t   : 4:4:4 colour driven onto the VGA pins
//   - vga_ctl_t : {hs, vs, vis} timing bits carried down the delay line
package vga_pkg;

    localparam int unsigned VGA_H_VIS  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;

    localparam int unsigned VGA_V_VIS  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;

    localparam int unsigned VGA_H_TOTAL      = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL      = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef logic [7:0] rgb8_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic hs;   // active low
        logic vs;   // active low
        logic vis;  // inside the visible area
    } vga_ctl_t;

    // Idle timing: both syncs inactive and blanked.
    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    // Widen RRRGGGBB to 4:4:4 by replicating the top bits into the LSBs,
    // so full-scale inputs map to full-scale outputs.
    function automatic rgb12_t expand_rgb(input rgb8_t c);
        rgb12_t o;
        o.r = {c[7:5], c[7]};
        o.g = {c[4:2], c[4]};
        o.b = {c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: pixel clock divider plus horizontal/vertical raster
// counters.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   x_o     horizontal count, 0..H_TOTAL-1
//   y_o     vertical count, 0..V_TOTAL-1
//   tick_o  one-clock pulse on every pixel advance (constant 1 when CLK_DIV=1)
//   sof_o   one-clock pulse when the counters wrap to (0,0)
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       tick_o,
    output logic       sof_o
);

    localparam int unsigned     DIV_W    = 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             tick_q, tick_d;
    logic             sof_q, sof_d;

    // The counters advance on the same edge that raises tick_q, so
    // tick_o is high exactly while the new pixel position is presented.
    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + DIV_W'(1);
        x_d    = x_q;
        y_d    = y_q;
        sof_d  = 1'b0;
        if (tick_d) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d   = '0;
                    sof_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            tick_q <= 1'b0;
            sof_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            sof_q  <= sof_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign tick_o = tick_q;
    assign sof_o  = sof_q;

endmodule

// File: rtl/vga_raster_out.sv
// vga_raster_out: display-side end of the object pipeline.
//   clk, resetN   system clock, asynchronous active-low reset
//   RGBIn         registered RRRGGGBB colour from the objects mux
//   pixelX/Y      raster position driven to every object drawer
//   pixelTick     one-clock pulse per pixel advance
//   startOfFrame  one-clock pulse when the raster wraps to (0,0)
//   vgaHS/vgaVS   active-low syncs, aligned with the colour pins
//   vgaBlankN     high only for visible pixels, aligned with the colour pins
//   vgaR/G/B      4:4:4 colour, forced to 0 outside the visible area
module vga_raster_out
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PIPE_DELAY = 1,
    parameter int unsigned H_VIS      = VGA_H_VIS,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_VIS      = VGA_V_VIS,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] RGBIn,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic       pixelTick,
    output logic       startOfFrame,
    output logic       vgaHS,
    output logic       vgaVS,
    output logic       vgaBlankN,
    output logic [3:0] vgaR,
    output logic [3:0] vgaG,
    output logic [3:0] vgaB
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS_C   = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C   = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_VIS + V_FP + V_SYNC - 1);

    vga_timing_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .clk_i  (clk),
        .rst_ni (resetN),
        .x_o    (pixelX),
        .y_o    (pixelY),
        .tick_o (pixelTick),
        .sof_o  (startOfFrame)
    );

    vga_ctl_t raw;

    always_comb begin
        raw.hs  = !((pixelX >= HS_FIRST) && (pixelX <= HS_LAST));
        raw.vs  = !((pixelY >= VS_FIRST) && (pixelY <= VS_LAST));
        raw.vis = (pixelX < H_VIS_C) && (pixelY < V_VIS_C);
    end

    // Delay line matches the mux latency so the timing bits reach the
    // output register together with the RGBIn computed for the same pixel.
    vga_ctl_t [PIPE_DELAY-1:0] dly_q, dly_d;
    vga_ctl_t [PIPE_DELAY:0]   dly_ext;

    always_comb begin
        dly_ext = {dly_q, raw};
        dly_d   = pixelTick ? dly_ext[PIPE_DELAY-1:0] : dly_q;
    end

    vga_ctl_t ctl_q, ctl_d;
    rgb12_t   rgb_q, rgb_d;

    always_comb begin
        ctl_d = ctl_q;
        rgb_d = rgb_q;
        if (pixelTick) begin
            ctl_d = dly_q[PIPE_DELAY-1];
            rgb_d = dly_q[PIPE_DELAY-1].vis ? expand_rgb(RGBIn) : '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dly_q <= {PIPE_DELAY{CTL_IDLE}};
            ctl_q <= CTL_IDLE;
            rgb_q <= '0;
        end else begin
            dly_q <= dly_d;
            ctl_q <= ctl_d;
            rgb_q <= rgb_d;
        end
    end

    assign vgaHS     = ctl_q.hs;
    assign vgaVS     = ctl_q.vs;
    assign vgaBlankN = ctl_q.vis;
    assign vgaR      = rgb_q.r;
    assign vgaG      = rgb_q.g;
    assign vgaB      = rgb_q.b;

endmodule

// File: tb/tb_vga_raster_out.sv
// Scoreboard bench for vga_raster_out. Horizontal timing is the full 800-pixel
// line; the vertical timing is shortened so several frames fit in the run.
module tb_vga_raster_out;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned PD      = 1;
    localparam int unsigned HV = 640, HF = 16, HSY = 96, HB = 48;
    localparam int unsigned VV = 6,   VF = 2,  VSY = 2,  VB = 3;
    localparam int unsigned HT    = HV + HF + HSY + HB;
    localparam int unsigned VT    = VV + VF + VSY + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam logic [14:0] IDLE_WORD = 15'h6000;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] RGBIn  = '0;
    logic [9:0] pixelX, pixelY;
    logic       pixelTick, startOfFrame, vgaHS, vgaVS, vgaBlankN;
    logic [3:0] vgaR, vgaG, vgaB;

    always #10 clk = ~clk;

    vga_raster_out #(
        .CLK_DIV    (CLK_DIV),
        .PIPE_DELAY (PD),
        .H_VIS      (HV),
        .H_FP       (HF),
        .H_SYNC     (HSY),
        .H_BP       (HB),
        .V_VIS      (VV),
        .V_FP       (VF),
        .V_SYNC     (VSY),
        .V_BP       (VB)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .RGBIn        (RGBIn),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .pixelTick    (pixelTick),
        .startOfFrame (startOfFrame),
        .vgaHS        (vgaHS),
        .vgaVS        (vgaVS),
        .vgaBlankN    (vgaBlankN),
        .vgaR         (vgaR),
        .vgaG         (vgaG),
        .vgaB         (vgaB)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          running = 1'b0;
    int unsigned cyc = 0;
    logic [14:0] sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected pin word {hs, vs, blankN, r, g, b} for frame position idx.
    function automatic logic [14:0] ref_pixel(input int unsigned idx, input int unsigned col);
        int unsigned x, y, r3, g3, b2, r, g, b;
        bit hs, vs, vis;
        x   = idx % HT;
        y   = idx / HT;
        hs  = !(x >= HV + HF && x < HV + HF + HSY);
        vs  = !(y >= VV + VF && y < VV + VF + VSY);
        vis = (x < HV) && (y < VV);
        r3  = (col >> 5) & 7;
        g3  = (col >> 2) & 7;
        b2  = col & 3;
        r   = vis ? 2 * r3 + ((r3 >= 4) ? 1 : 0) : 0;
        g   = vis ? 2 * g3 + ((g3 >= 4) ? 1 : 0) : 0;
        b   = vis ? b2 * 5 : 0;
        return {hs, vs, vis, 4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_pixelX"}, pixelX, 0);
        check({tag, "_pixelY"}, pixelY, 0);
        check({tag, "_pixelTick"}, pixelTick, 0);
        check({tag, "_startOfFrame"}, startOfFrame, 0);
        check({tag, "_vgaHS"}, vgaHS, 1);
        check({tag, "_vgaVS"}, vgaVS, 1);
        check({tag, "_vgaBlankN"}, vgaBlankN, 0);
        check({tag, "_vgaRGB"}, {vgaR, vgaG, vgaB}, 0);
    endtask

    // clocks since reset release
    always @(posedge clk) cyc <= running ? cyc + 1 : 0;

    // Raster counters against clock-count arithmetic.
    int unsigned ck_k, ck_idx;
    bit          ck_tick;
    always @(posedge clk) begin
        #1;
        if (running) begin
            ck_k    = cyc / CLK_DIV;
            ck_idx  = ck_k % FRAME;
            ck_tick = (cyc >= CLK_DIV) && (cyc % CLK_DIV == 0);
            check("pixelX", pixelX, ck_idx % HT);
            check("pixelY", pixelY, ck_idx / HT);
            check("pixelTick", pixelTick, ck_tick);
            check("startOfFrame", startOfFrame, ck_tick && ck_k > 0 && ck_idx == 0);
        end
    end

    // Stimulus: a mux model registering one colour per pixel on the
    // pixelTick edge; expected pin word pushed for that pixel.
    int unsigned st_k, st_idx, st_x, st_y, st_f, st_col;
    always @(posedge clk) begin
        #1;
        if (running && cyc > CLK_DIV && (cyc - 1) % CLK_DIV == 0) begin
            st_k   = (cyc - 1) / CLK_DIV;
            st_idx = st_k % FRAME;
            st_x   = st_idx % HT;
            st_y   = st_idx / HT;
            st_f   = st_k / FRAME;
            if (st_f == 0) begin
                if (st_y < VV && st_x == 100)      st_col = 32'hE3;
                else if (st_y < VV && st_x == 101) st_col = 32'h92;
                else                               st_col = $urandom_range(0, 255);
            end else if (st_f == 1) begin
                st_col = 32'hFF;
            end else begin
                st_col = st_x & 32'hFF;
            end
            RGBIn = 8'(st_col);
            sbq.push_back(ref_pixel(st_idx, st_col));
        end
    end

    // Monitor: compares the pins after every output-register update.
    int unsigned mn_k;
    logic [14:0] mn_act, mn_exp;
    always @(posedge clk) begin
        #1;
        if (!running) begin
            sbq.delete();
        end else if (cyc > CLK_DIV && (cyc - 1) % CLK_DIV == 0) begin
            mn_k   = (cyc - 1) / CLK_DIV;
            mn_act = {vgaHS, vgaVS, vgaBlankN, vgaR, vgaG, vgaB};
            if (mn_k <= PD) begin
                check("pins_flush", mn_act, IDLE_WORD);
            end else if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got pins 0x%0h, expected a queued pixel (t=%0t)", mn_act, $time);
            end else begin
                mn_exp = sbq.pop_front();
                check("pins", mn_act, mn_exp);
            end
        end
    end

    // Edge-level timing of syncs, blank and startOfFrame, in clocks.
    bit          prev_hs = 1'b1, prev_vs = 1'b1, prev_bn = 1'b0;
    bit          have_hs = 1'b0, have_vs = 1'b0, have_sof = 1'b0;
    int unsigned hs_fall, vs_fall, sof_at, tr_pix;
    always @(posedge clk) begin
        #1;
        if (!running) begin
            have_hs  = 1'b0;
            have_vs  = 1'b0;
            have_sof = 1'b0;
            prev_hs  = 1'b1;
            prev_vs  = 1'b1;
            prev_bn  = 1'b0;
        end else begin
            tr_pix = (cyc - 1) / CLK_DIV - PD;  // pixel index now on the pins
            if (prev_hs && !vgaHS) begin
                if (have_hs) check("hs_period", cyc - hs_fall, HT * CLK_DIV);
                check("hs_fall_x", tr_pix % HT, HV + HF);
                hs_fall = cyc;
                have_hs = 1'b1;
            end
            if (!prev_hs && vgaHS && have_hs) check("hs_width", cyc - hs_fall, HSY * CLK_DIV);
            if (prev_vs && !vgaVS) begin
                vs_fall = cyc;
                have_vs = 1'b1;
            end
            if (!prev_vs && vgaVS && have_vs) check("vs_width", cyc - vs_fall, VSY * HT * CLK_DIV);
            if (startOfFrame) begin
                if (have_sof) check("sof_period", cyc - sof_at, FRAME * CLK_DIV);
                sof_at   = cyc;
                have_sof = 1'b1;
            end
            if (!prev_bn && vgaBlankN && tr_pix >= HT) begin
                check("blank_rise_x", tr_pix % HT, 0);
                if (tr_pix / FRAME >= 2) check("align_x0_rgb", {vgaR, vgaG, vgaB}, 0);
            end
            prev_hs = vgaHS;
            prev_vs = vgaVS;
            prev_bn = vgaBlankN;
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check_reset_state("reset0");
        @(negedge clk);
        resetN  = 1'b1;
        running = 1'b1;
        repeat (CLK_DIV * (2 * FRAME + 2000)) @(posedge clk);

        // asynchronous reset in the middle of a frame
        @(negedge clk);
        #3;
        resetN  = 1'b0;
        running = 1'b0;
        #1;
        check_reset_state("reset_async");
        repeat (5) @(posedge clk);
        #1;
        check_reset_state("reset_hold");
        @(negedge clk);
        resetN  = 1'b1;
        running = 1'b1;
        repeat (200) @(posedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_raster_out.md
Name: vga_raster_out

Overview:
- Display-side end of the object pipeline.
- Generates 640x480@60 raster timing and drives pixelX/pixelY to every object drawer.
- Samples the registered 8-bit RGB that the objects mux returns for each pixel, then drives VGA sync, blank and 4:4:4 colour pins.
- Delays sync/blank so they line up with the mux's registered RGB.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 at 50 MHz gives a 25 MHz pixel rate); legal values 1..4.
- PIPE_DELAY, 1, pixel ticks between pixelX/pixelY leaving this block and the matching RGBIn being valid; legal values 1..3.
- H_VIS, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- RGBIn  in  8  pixel colour from the objects mux, RRRGGGBB
- pixelX  out  10  current horizontal count, 0..H_total-1
- pixelY  out  10  current vertical count, 0..V_total-1
- pixelTick  out  1  one-clk pulse marking each pixel advance
- startOfFrame  out  1  one-clk pulse when the counters wrap to (0,0)
- vgaHS  out  1  horizontal sync, active low
- vgaVS  out  1  vertical sync, active low
- vgaBlankN  out  1  high only during visible pixels, delay-aligned
- vgaR  out  4  red
- vgaG  out  4  green
- vgaB  out  4  blue

Behaviour:
- Reset (asynchronous, any time): divider, counters and delay line are cleared.
  - pixelX = 0, pixelY = 0; pixelTick, startOfFrame, vgaBlankN = 0.
  - vgaHS = 1, vgaVS = 1; vgaR/G/B = 0.
  - After release, the first pixelTick occurs CLK_DIV clocks later.
- Divider: counts 0..CLK_DIV-1 and asserts pixelTick on the clock where it equals CLK_DIV-1. With CLK_DIV=1, pixelTick is constantly 1.
- Horizontal counter:
  - Increments on pixelTick.
  - At H_total-1 = 799 it wraps to 0, and the vertical counter increments in the same tick.
- Vertical counter: at V_total-1 = 524 it wraps to 0. startOfFrame pulses on the clock where both counters become 0, coincident with that pixelTick.
- Raw timing, derived combinationally from the counters:
  - hs_raw low for 656 <= x <= 751.
  - vs_raw low for 490 <= y <= 491.
  - vis_raw = (x < 640) && (y < 480).
- Delay line: a PIPE_DELAY-deep shift register of {hs_raw, vs_raw, vis_raw}, advanced only on pixelTick. The output stage uses the last entry.
- Output stage: registered and updated only on pixelTick.
  - RGBIn is sampled once per pixel on that tick.
  - If the delayed vis bit is 0, vgaR/G/B are forced to 0 regardless of RGBIn.
  - Otherwise the colour expands by bit replication: R = {RGBIn[7:5], RGBIn[7]}, G = {RGBIn[4:2], RGBIn[4]}, B = {RGBIn[1:0], RGBIn[1:0]}.
  - vgaHS, vgaVS and vgaBlankN come from the delayed bits in the same register.
- Alignment: pixel (x,y) appears on the pins PIPE_DELAY+1 ticks after pixelX/pixelY first show (x,y). Sync and blank carry the identical offset.
- Between ticks, all outputs hold.
- Widths: counters are 10 bits. All comparisons use constants computed from the parameters. There is no overflow path, because the wrap happens before 1023.

Decomposition:
- Package vga_pkg holds:
  - the H/V timing localparams and the derived totals, sync start and sync end;
  - typedef rgb8_t (8 bits);
  - typedef rgb12_t struct {r, g, b: 4 bits each}.
- One natural sub-module: vga_timing_counter (divider plus the H/V counters, pixelTick and startOfFrame). The delay line and colour expansion stay in the top module.

Test Plan:
- Reset: hold resetN = 0 mid-frame for 5 clks. Require all outputs at their reset values; after release, the first pixelTick comes at clock CLK_DIV and pixelX = 1 after that tick.
- Line timing, CLK_DIV = 2: count clocks between successive vgaHS falling edges = 1600. Require a low width of 192 clocks, and the falling edge when the delayed x equals 656.
- Frame timing: vgaVS low for exactly 2 lines (1600 pixels). startOfFrame pulses every 420000 ticks; check the full frame period.
- Colour expansion: drive RGBIn = 8'hE3 in the visible area. Require vgaR = 4'hF, vgaG = 4'h0, vgaB = 4'hF. Then drive RGBIn = 8'h92 and require vgaR = 4'h9, vgaG = 4'h9, vgaB = 4'hA.
- Blanking: drive RGBIn = 8'hFF constantly. Require vgaR/G/B = 0 and vgaBlankN = 0 for every pixel with delayed x >= 640 or y >= 480, including the x = 639/640 edge.
- Alignment, PIPE_DELAY = 1: a model mux returns RGBIn = pixelX[7:0], registered once. Require the pin colour at x = 0 to come from RGBIn = 0, and vgaBlankN to rise on exactly that pixel.
